// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if
//   Bundles the ID-stage inputs, the control inputs and the registered
//   EX-stage outputs of the ID/EX pipeline register.
//   master : decode / hazard-control side (drives *_id, flush_ex, hold)
//   slave  : the id_ex_pipe register itself (drives *_ex, stall_fe, counters)
//   Parameters: XLEN datapath width, CNT_W performance counter width.
interface id_ex_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    // decode stage
    logic            valid_id;
    logic [XLEN-1:0] pc_id;
    logic [XLEN-1:0] rs1_data_id;
    logic [XLEN-1:0] rs2_data_id;
    logic [XLEN-1:0] imm_id;
    logic [4:0]      rs1_id;
    logic [4:0]      rs2_id;
    logic [4:0]      rd_id;
    logic            RuWr_id;
    logic            MemRd_id;
    logic            MemWr_id;
    logic [3:0]      ALUOp_id;
    logic            ALUASrc_id;
    logic            ALUBSrc_id;
    logic [1:0]      RUDataWrSrc_id;
    logic [4:0]      BrOp_id;
    // pipeline control
    logic            flush_ex;
    logic            hold;
    // execute stage
    logic            valid_ex;
    logic [XLEN-1:0] pc_ex;
    logic [XLEN-1:0] rs1_data_ex;
    logic [XLEN-1:0] rs2_data_ex;
    logic [XLEN-1:0] imm_ex;
    logic [4:0]      rs1_ex;
    logic [4:0]      rs2_ex;
    logic [4:0]      rd_ex;
    logic            RuWr_ex;
    logic            MemRd_ex;
    logic            MemWr_ex;
    logic [3:0]      ALUOp_ex;
    logic            ALUASrc_ex;
    logic            ALUBSrc_ex;
    logic [1:0]      RUDataWrSrc_ex;
    logic [4:0]      BrOp_ex;
    // status
    logic             stall_fe;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
               rs1_id, rs2_id, rd_id, RuWr_id, MemRd_id, MemWr_id,
               ALUOp_id, ALUASrc_id, ALUBSrc_id, RUDataWrSrc_id, BrOp_id,
               flush_ex, hold,
        input  valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
               rs1_ex, rs2_ex, rd_ex, RuWr_ex, MemRd_ex, MemWr_ex,
               ALUOp_ex, ALUASrc_ex, ALUBSrc_ex, RUDataWrSrc_ex, BrOp_ex,
               stall_fe, bubble_cnt, flush_cnt
    );

    modport slave (
        input  valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
               rs1_id, rs2_id, rd_id, RuWr_id, MemRd_id, MemWr_id,
               ALUOp_id, ALUASrc_id, ALUBSrc_id, RUDataWrSrc_id, BrOp_id,
               flush_ex, hold,
        output valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
               rs1_ex, rs2_ex, rd_ex, RuWr_ex, MemRd_ex, MemWr_ex,
               ALUOp_ex, ALUASrc_ex, ALUBSrc_ex, RUDataWrSrc_ex, BrOp_ex,
               stall_fe, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// id_ex_pipe
//   ID/EX pipeline register with load-use hazard detection, branch flush,
//   global hold and saturating bubble/flush counters.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (EX becomes a bubble, counters 0)
//     bus    id_ex_pipe_if.slave: *_id in, flush_ex/hold in,
//            *_ex out, stall_fe out, bubble_cnt/flush_cnt out
module id_ex_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    id_ex_pipe_if.slave   bus
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            RuWr;
        logic            MemRd;
        logic            MemWr;
        logic [3:0]      ALUOp;
        logic            ALUASrc;
        logic            ALUBSrc;
        logic [1:0]      RUDataWrSrc;
        logic [4:0]      BrOp;
    } ex_fields_t;

    // An all-zero record is a bubble: no writes, no memory access, no
    // branch, and register indices of x0 so forwarding never matches.
    ex_fields_t       r_ex;
    ex_fields_t       w_id;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_lu;

    always_comb begin
        w_id             = '0;
        w_id.valid       = bus.valid_id;
        w_id.pc          = bus.pc_id;
        w_id.rs1_data    = bus.rs1_data_id;
        w_id.rs2_data    = bus.rs2_data_id;
        w_id.imm         = bus.imm_id;
        w_id.rs1         = bus.rs1_id;
        w_id.rs2         = bus.rs2_id;
        w_id.rd          = bus.rd_id;
        w_id.RuWr        = bus.RuWr_id;
        w_id.MemRd       = bus.MemRd_id;
        w_id.MemWr       = bus.MemWr_id;
        w_id.ALUOp       = bus.ALUOp_id;
        w_id.ALUASrc     = bus.ALUASrc_id;
        w_id.ALUBSrc     = bus.ALUBSrc_id;
        w_id.RUDataWrSrc = bus.RUDataWrSrc_id;
        w_id.BrOp        = bus.BrOp_id;
    end

    // Load in EX whose destination is a source of the instruction in ID.
    assign w_lu = bus.valid_id & r_ex.valid & r_ex.MemRd & r_ex.RuWr &
                  (r_ex.rd != 5'd0) &
                  ((r_ex.rd == bus.rs1_id) | (r_ex.rd == bus.rs2_id));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex         <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (bus.flush_ex) begin
            r_ex <= '0;
            if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
        end else if (bus.hold) begin
            r_ex <= r_ex;
        end else if (w_lu) begin
            r_ex <= '0;
            if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end else begin
            r_ex <= bus.valid_id ? w_id : '0;
        end
    end

    // Gated by rst_n so every output reads 0 while reset is asserted,
    // even if hold is driven high during reset.
    assign bus.stall_fe = rst_n & (bus.hold | w_lu) & ~bus.flush_ex;

    assign bus.valid_ex       = r_ex.valid;
    assign bus.pc_ex          = r_ex.pc;
    assign bus.rs1_data_ex    = r_ex.rs1_data;
    assign bus.rs2_data_ex    = r_ex.rs2_data;
    assign bus.imm_ex         = r_ex.imm;
    assign bus.rs1_ex         = r_ex.rs1;
    assign bus.rs2_ex         = r_ex.rs2;
    assign bus.rd_ex          = r_ex.rd;
    assign bus.RuWr_ex        = r_ex.RuWr;
    assign bus.MemRd_ex       = r_ex.MemRd;
    assign bus.MemWr_ex       = r_ex.MemWr;
    assign bus.ALUOp_ex       = r_ex.ALUOp;
    assign bus.ALUASrc_ex     = r_ex.ALUASrc;
    assign bus.ALUBSrc_ex     = r_ex.ALUBSrc;
    assign bus.RUDataWrSrc_ex = r_ex.RUDataWrSrc;
    assign bus.BrOp_ex        = r_ex.BrOp;
    assign bus.bubble_cnt     = r_bubble_cnt;
    assign bus.flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    id_ex_pipe_if #(.XLEN(32), .CNT_W(16)) bus ();
    id_ex_pipe_if #(.XLEN(32), .CNT_W(2))  bus2 ();

    id_ex_pipe #(.XLEN(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    id_ex_pipe #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Data fields are derived from pc so each instruction is recognisable.
    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic ruwr, input logic memrd,
                            input logic [31:0] pc);
        bus.valid_id       = v;
        bus.pc_id          = pc;
        bus.rs1_data_id    = pc + 32'd1;
        bus.rs2_data_id    = pc + 32'd2;
        bus.imm_id         = pc + 32'd3;
        bus.rs1_id         = rs1;
        bus.rs2_id         = rs2;
        bus.rd_id          = rd;
        bus.RuWr_id        = ruwr;
        bus.MemRd_id       = memrd;
        bus.MemWr_id       = 1'b0;
        bus.ALUOp_id       = rd[3:0];
        bus.ALUASrc_id     = rs1[0];
        bus.ALUBSrc_id     = memrd;
        bus.RUDataWrSrc_id = {1'b0, memrd};
        bus.BrOp_id        = 5'd0;
    endtask

    task automatic drive_id2(input logic v, input logic [4:0] rs1, input logic [4:0] rd,
                             input logic memrd);
        bus2.valid_id       = v;
        bus2.pc_id          = 32'h200;
        bus2.rs1_data_id    = 32'h0;
        bus2.rs2_data_id    = 32'h0;
        bus2.imm_id         = 32'h0;
        bus2.rs1_id         = rs1;
        bus2.rs2_id         = 5'd0;
        bus2.rd_id          = rd;
        bus2.RuWr_id        = 1'b1;
        bus2.MemRd_id       = memrd;
        bus2.MemWr_id       = 1'b0;
        bus2.ALUOp_id       = 4'd0;
        bus2.ALUASrc_id     = 1'b0;
        bus2.ALUBSrc_id     = 1'b0;
        bus2.RUDataWrSrc_id = 2'd0;
        bus2.BrOp_id        = 5'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        drive_id2(1'b0, 5'd0, 5'd0, 1'b0);
        bus.flush_ex = 1'b0; bus.hold = 1'b0;
        bus2.flush_ex = 1'b0; bus2.hold = 1'b0;
        #12;
        n_total++; if (bus.valid_ex !== 1'b0) $display("FAIL reset_valid_ex: got %b want 0", bus.valid_ex); else n_pass++;
        n_total++; if (bus.pc_ex !== 32'h0) $display("FAIL reset_pc_ex: got %h want 0", bus.pc_ex); else n_pass++;
        n_total++; if (bus.stall_fe !== 1'b0) $display("FAIL reset_stall_fe: got %b want 0", bus.stall_fe); else n_pass++;
        n_total++; if (bus.bubble_cnt !== 16'd0) $display("FAIL reset_bubble_cnt: got %0d want 0", bus.bubble_cnt); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        // add x3, x1, x2
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h100);
        #1;
        n_total++; if (bus.stall_fe !== 1'b0) $display("FAIL normal_stall_fe: got %b want 0", bus.stall_fe); else n_pass++;
        tick();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        n_total++; if (bus.rs1_ex !== 5'd1) $display("FAIL normal_rs1_ex: got %0d want 1", bus.rs1_ex); else n_pass++;
        n_total++; if (bus.rs2_ex !== 5'd2) $display("FAIL normal_rs2_ex: got %0d want 2", bus.rs2_ex); else n_pass++;
        n_total++; if (bus.rd_ex !== 5'd3) $display("FAIL normal_rd_ex: got %0d want 3", bus.rd_ex); else n_pass++;
        n_total++; if (bus.RuWr_ex !== 1'b1) $display("FAIL normal_RuWr_ex: got %b want 1", bus.RuWr_ex); else n_pass++;
        n_total++; if (bus.valid_ex !== 1'b1) $display("FAIL normal_valid_ex: got %b want 1", bus.valid_ex); else n_pass++;
        n_total++; if (bus.pc_ex !== 32'h100) $display("FAIL normal_pc_ex: got %h want 100", bus.pc_ex); else n_pass++;
        n_total++; if (bus.rs2_data_ex !== 32'h102) $display("FAIL normal_rs2_data_ex: got %h want 102", bus.rs2_data_ex); else n_pass++;
        n_total++; if (bus.imm_ex !== 32'h103) $display("FAIL normal_imm_ex: got %h want 103", bus.imm_ex); else n_pass++;
        n_total++; if (bus.ALUOp_ex !== 4'd3) $display("FAIL normal_ALUOp_ex: got %0d want 3", bus.ALUOp_ex); else n_pass++;
        n_total++; if (bus.MemRd_ex !== 1'b0) $display("FAIL normal_MemRd_ex: got %b want 0", bus.MemRd_ex); else n_pass++;
        // invalid ID loads a bubble
        tick();
        n_total++; if (bus.valid_ex !== 1'b0) $display("FAIL invalid_id_valid_ex: got %b want 0", bus.valid_ex); else n_pass++;
        n_total++; if (bus.rd_ex !== 5'd0) $display("FAIL invalid_id_rd_ex: got %0d want 0", bus.rd_ex); else n_pass++;
    endtask

    task automatic test_load_use();
        // lw x5, 0(x1)
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'h110);
        tick();
        // add x6, x5, x7
        drive_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 32'h114);
        #1;
        n_total++; if (bus.stall_fe !== 1'b1) $display("FAIL lu_stall_fe: got %b want 1", bus.stall_fe); else n_pass++;
        tick();
        n_total++; if (bus.valid_ex !== 1'b0) $display("FAIL lu_bubble_valid_ex: got %b want 0", bus.valid_ex); else n_pass++;
        n_total++; if (bus.rd_ex !== 5'd0) $display("FAIL lu_bubble_rd_ex: got %0d want 0", bus.rd_ex); else n_pass++;
        n_total++; if (bus.stall_fe !== 1'b0) $display("FAIL lu_stall_drop: got %b want 0", bus.stall_fe); else n_pass++;
        n_total++; if (bus.bubble_cnt !== 16'd1) $display("FAIL lu_bubble_cnt: got %0d want 1", bus.bubble_cnt); else n_pass++;
        tick();
        n_total++; if (bus.rd_ex !== 5'd6) $display("FAIL lu_add_rd_ex: got %0d want 6", bus.rd_ex); else n_pass++;
        n_total++; if (bus.rs1_ex !== 5'd5) $display("FAIL lu_add_rs1_ex: got %0d want 5", bus.rs1_ex); else n_pass++;
        n_total++; if (bus.valid_ex !== 1'b1) $display("FAIL lu_add_valid_ex: got %b want 1", bus.valid_ex); else n_pass++;
        n_total++; if (bus.bubble_cnt !== 16'd1) $display("FAIL lu_bubble_cnt_hold: got %0d want 1", bus.bubble_cnt); else n_pass++;
        // load to x0 followed by a reader of x0: no hazard
        drive_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 32'h118);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 32'h11c);
        #1;
        n_total++; if (bus.stall_fe !== 1'b0) $display("FAIL lu_x0_stall_fe: got %b want 0", bus.stall_fe); else n_pass++;
        tick();
        n_total++; if (bus.rd_ex !== 5'd8) $display("FAIL lu_x0_rd_ex: got %0d want 8", bus.rd_ex); else n_pass++;
    endtask

    task automatic test_flush_lu();
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'h120);
        tick();
        drive_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 32'h124);
        bus.flush_ex = 1'b1;
        #1;
        n_total++; if (bus.stall_fe !== 1'b0) $display("FAIL flush_stall_fe: got %b want 0", bus.stall_fe); else n_pass++;
        tick();
        bus.flush_ex = 1'b0;
        n_total++; if (bus.valid_ex !== 1'b0) $display("FAIL flush_valid_ex: got %b want 0", bus.valid_ex); else n_pass++;
        n_total++; if (bus.MemRd_ex !== 1'b0) $display("FAIL flush_MemRd_ex: got %b want 0", bus.MemRd_ex); else n_pass++;
        n_total++; if (bus.flush_cnt !== 16'd1) $display("FAIL flush_flush_cnt: got %0d want 1", bus.flush_cnt); else n_pass++;
        n_total++; if (bus.bubble_cnt !== 16'd1) $display("FAIL flush_bubble_cnt: got %0d want 1", bus.bubble_cnt); else n_pass++;
    endtask

    task automatic test_hold();
        drive_id(1'b1, 5'd2, 5'd4, 5'd9, 1'b1, 1'b0, 32'h130);
        tick();
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 5'd3, 5'd4, 5'(10 + i), 1'b1, 1'b0, 32'h134 + 32'(4 * i));
            #1;
            n_total++; if (bus.stall_fe !== 1'b1) $display("FAIL hold_stall_fe[%0d]: got %b want 1", i, bus.stall_fe); else n_pass++;
            tick();
            n_total++; if (bus.rd_ex !== 5'd9) $display("FAIL hold_rd_ex[%0d]: got %0d want 9", i, bus.rd_ex); else n_pass++;
            n_total++; if (bus.pc_ex !== 32'h130) $display("FAIL hold_pc_ex[%0d]: got %h want 130", i, bus.pc_ex); else n_pass++;
            n_total++; if (bus.flush_cnt !== 16'd1 || bus.bubble_cnt !== 16'd1)
                $display("FAIL hold_cnts[%0d]: got flush=%0d bubble=%0d want 1/1", i, bus.flush_cnt, bus.bubble_cnt); else n_pass++;
        end
        bus.hold = 1'b0;
        tick();
        n_total++; if (bus.rd_ex !== 5'd12) $display("FAIL hold_release_rd_ex: got %0d want 12", bus.rd_ex); else n_pass++;
        n_total++; if (bus.pc_ex !== 32'h13c) $display("FAIL hold_release_pc_ex: got %h want 13c", bus.pc_ex); else n_pass++;
    endtask

    task automatic test_reset_mid();
        // EX holds the valid rd=12 instruction; assert reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.valid_ex !== 1'b0) $display("FAIL rstmid_valid_ex: got %b want 0", bus.valid_ex); else n_pass++;
        n_total++; if (bus.rd_ex !== 5'd0) $display("FAIL rstmid_rd_ex: got %0d want 0", bus.rd_ex); else n_pass++;
        n_total++; if (bus.RuWr_ex !== 1'b0) $display("FAIL rstmid_RuWr_ex: got %b want 0", bus.RuWr_ex); else n_pass++;
        n_total++; if (bus.stall_fe !== 1'b0) $display("FAIL rstmid_stall_fe: got %b want 0", bus.stall_fe); else n_pass++;
        n_total++; if (bus.bubble_cnt !== 16'd0) $display("FAIL rstmid_bubble_cnt: got %0d want 0", bus.bubble_cnt); else n_pass++;
        n_total++; if (bus.flush_cnt !== 16'd0) $display("FAIL rstmid_flush_cnt: got %0d want 0", bus.flush_cnt); else n_pass++;
        #2;
        rst_n = 1'b1;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        for (int i = 0; i < 5; i++) begin
            drive_id2(1'b1, 5'd1, 5'd5, 1'b1);
            tick();
            drive_id2(1'b1, 5'd5, 5'd6, 1'b0);
            tick();
            n_total++; if (bus2.bubble_cnt !== exp_cnt[i])
                $display("FAIL sat_bubble_cnt[%0d]: got %0d want %0d", i, bus2.bubble_cnt, exp_cnt[i]); else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_normal();
        test_load_use();
        test_flush_lu();
        test_hold();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
